// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - AXI master bus bundle for the cache memory arbiter
//
// Purpose: groups the five AXI channels (AR, R, AW, W, B) used by the arbiter.
// Modports:
//   master - arbiter side: drives AR/AW/W payload and VALIDs, RREADY, BREADY
//   slave  - memory side: drives ARREADY, AWREADY, WREADY and the R/B channels
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [3:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arvalid;
  logic              arready;

  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  logic [ID_W-1:0]   awid;
  logic [ADDR_W-1:0] awaddr;
  logic [3:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;
  logic              awvalid;
  logic              awready;

  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              wlast;
  logic              wvalid;
  logic              wready;

  logic [ID_W-1:0]   bid;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - round-robin I/D cache arbiter onto one AXI master port
//
// Purpose: arbitrates the I-cache and D-cache req/wait interfaces, latches the
// winner and runs either a RD_BEATS line-fill INCR read or a single-beat write.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   i_req/i_addr                 I-cache read request (read only)
//   i_wait/i_rdata/i_rvalid      I-cache stall and read beats
//   d_req/d_write/d_addr/
//   d_wdata/d_type               D-cache request, write data right-aligned
//   d_wait/d_rdata/d_rvalid      D-cache stall and read beats
//   bus_err                      pulse at completion if any RRESP/BRESP was nonzero
//   axi                          AXI master channels (cache_mem_arbiter_if.master)
module cache_mem_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int ID_W     = 4,
  parameter int RD_BEATS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_wait,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_rvalid,
  input  logic              d_req,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [1:0]        d_type,
  output logic              d_wait,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              bus_err,
  cache_mem_arbiter_if.master axi
);
  localparam int OFF_W = $clog2(RD_BEATS * 4);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B} state_t;

  state_t            state, state_nxt;
  // owner / last_grant / grant_d: 0 = I-cache, 1 = D-cache
  logic              owner, last_grant, grant_vld, grant_d;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [1:0]        lat_type;
  logic              err_acc;
  logic              beat, rd_done, wr_done, done;
  logic              ar_on, aw_on, w_on;
  logic              unused_id;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_type   <= 2'd0;
      err_acc    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant_vld) begin
        owner      <= grant_d;
        last_grant <= grant_d;
        lat_addr   <= grant_d ? d_addr : i_addr;
        lat_wdata  <= grant_d ? d_wdata : '0;
        lat_type   <= grant_d ? d_type : 2'd0;
      end
      if (state == S_IDLE)
        err_acc <= 1'b0;
      else if ((beat && axi.rresp != 2'b00) || (state == S_B && axi.bvalid && axi.bresp != 2'b00))
        err_acc <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_vld = 1'b0;
    grant_d   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_req && d_req) begin
          grant_vld = 1'b1;
          grant_d   = ~last_grant;  // tie goes to whoever did not win last
        end else if (i_req || d_req) begin
          grant_vld = 1'b1;
          grant_d   = d_req;
        end
        if (grant_vld)
          state_nxt = (grant_d && d_write) ? S_AW : S_AR;
      end
      S_AR:    if (axi.arready) state_nxt = S_R;
      S_R:     if (axi.rvalid && axi.rlast) state_nxt = S_IDLE;
      S_AW:    if (axi.awready) state_nxt = S_W;
      S_W:     if (axi.wready) state_nxt = S_B;
      S_B:     if (axi.bvalid) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign beat    = (state == S_R) && axi.rvalid;
  assign rd_done = beat && axi.rlast;
  assign wr_done = (state == S_B) && axi.bvalid;
  assign done    = rd_done || wr_done;

  assign i_wait   = i_req && !(!owner && done);
  assign d_wait   = d_req && !(owner && done);
  assign i_rvalid = beat && !owner;
  assign d_rvalid = beat && owner;
  assign i_rdata  = i_rvalid ? axi.rdata : '0;
  assign d_rdata  = d_rvalid ? axi.rdata : '0;
  assign bus_err  = done && (err_acc || (rd_done && axi.rresp != 2'b00) ||
                             (wr_done && axi.bresp != 2'b00));

  // Routing relies on the latched owner; returned IDs are deliberately ignored.
  assign unused_id = ^{axi.rid, axi.bid};

  assign ar_on = (state == S_AR);
  assign aw_on = (state == S_AW);
  assign w_on  = (state == S_W);

  assign axi.arvalid = ar_on;
  assign axi.arid    = ar_on ? ID_W'(owner) : '0;
  assign axi.araddr  = ar_on ? (lat_addr & LINE_MASK) : '0;
  assign axi.arlen   = ar_on ? 4'(RD_BEATS - 1) : 4'd0;
  assign axi.arsize  = ar_on ? 3'd2 : 3'd0;
  assign axi.arburst = ar_on ? 2'b01 : 2'b00;
  assign axi.rready  = (state == S_R);

  assign axi.awvalid = aw_on;
  assign axi.awid    = aw_on ? ID_W'(1) : '0;
  assign axi.awaddr  = aw_on ? lat_addr : '0;
  assign axi.awlen   = 4'd0;
  assign axi.awsize  = aw_on ? 3'd2 : 3'd0;
  assign axi.awburst = aw_on ? 2'b01 : 2'b00;

  assign axi.wvalid  = w_on;
  assign axi.wlast   = w_on;
  assign axi.bready  = (state == S_B);

  // Sub-word writes replicate the datum across lanes so the strobe alone selects it.
  always_comb begin
    axi.wstrb = 4'b0000;
    axi.wdata = '0;
    if (w_on) begin
      unique case (lat_type)
        2'd0: begin
          axi.wstrb = 4'b0001 << lat_addr[1:0];
          axi.wdata = {4{lat_wdata[7:0]}};
        end
        2'd1: begin
          axi.wstrb = 4'b0011 << {lat_addr[1], 1'b0};
          axi.wdata = {2{lat_wdata[15:0]}};
        end
        default: begin
          axi.wstrb = 4'b1111;
          axi.wdata = lat_wdata;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;
  localparam int RD_BEATS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_wait, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_write, d_wait, d_rvalid, bus_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [1:0]  d_type;

  always #5 clk = ~clk;

  cache_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) axi ();

  cache_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .ID_W(4), .RD_BEATS(RD_BEATS)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_wait(i_wait), .i_rdata(i_rdata), .i_rvalid(i_rvalid),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_type(d_type),
    .d_wait(d_wait), .d_rdata(d_rdata), .d_rvalid(d_rvalid), .bus_err(bus_err),
    .axi(axi)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        owner;
    logic [31:0] data;
  } beat_t;
  beat_t sbq[$];

  typedef struct {
    logic        is_d;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  typ;
    int          ar_dly;
    int          gap;
    logic [1:0]  resp;
    logic [31:0] exp_addr;
    logic [3:0]  exp_id;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic        exp_err;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Scoreboard: each read beat the bench drives is queued; every rvalid pops one.
  always @(negedge clk) begin
    if (!rst && (i_rvalid || d_rvalid)) begin
      chk("rvalid_exclusive", 32'(i_rvalid & d_rvalid), 32'd0);
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected_beat: got i=%0b d=%0b, want none", i_rvalid, d_rvalid);
      end else begin
        beat_t e;
        e = sbq.pop_front();
        chk("sb_owner", 32'(d_rvalid), 32'(e.owner));
        chk("sb_data", d_rvalid ? d_rdata : i_rdata, e.data);
      end
    end
  end

  task automatic drive_req(input vec_t v);
    if (v.is_d) begin
      d_req = 1'b1; d_write = v.wr; d_addr = v.addr; d_wdata = v.wdata; d_type = v.typ;
    end else begin
      i_req = 1'b1; i_addr = v.addr;
    end
  endtask

  task automatic serve_read(input logic own, input logic [31:0] exp_addr, input logic [3:0] exp_id,
                            input int ar_dly, input int gap, input logic [1:0] resp, input logic exp_err);
    int n = 0;
    logic [31:0] d;
    mid();
    while (!axi.arvalid && n < 20) begin
      next_cycle();
      mid();
      n++;
    end
    chk("ar_latency", 32'(n), 32'd1);
    // Stray RVALID|RLAST while still in AR must be ignored.
    axi.rvalid = (ar_dly > 0);
    axi.rlast  = 1'b1;
    for (int k = 0; k < ar_dly; k++) begin
      next_cycle();
      mid();
      chk("ar_hold_valid", 32'(axi.arvalid), 32'd1);
      chk("ar_hold_addr", axi.araddr, exp_addr);
      chk("ar_stray_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
    end
    axi.rvalid  = 1'b0;
    axi.rlast   = 1'b0;
    axi.arready = 1'b1;
    chk("araddr", axi.araddr, exp_addr);
    chk("arlen", 32'(axi.arlen), 32'(RD_BEATS - 1));
    chk("arid", 32'(axi.arid), 32'(exp_id));
    chk("arsize", 32'(axi.arsize), 32'd2);
    chk("arburst", 32'(axi.arburst), 32'd1);
    chk("ar_wait", 32'(own ? d_wait : i_wait), 32'd1);
    next_cycle();
    axi.arready = 1'b0;
    for (int b = 0; b < RD_BEATS; b++) begin
      for (int g = 0; g < ((b > 0) ? gap : 0); g++) begin
        mid();
        chk("gap_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
        chk("gap_wait", 32'(own ? d_wait : i_wait), 32'd1);
        next_cycle();
      end
      d = $urandom;
      axi.rvalid = 1'b1;
      axi.rdata  = d;
      axi.rlast  = (b == RD_BEATS - 1);
      axi.rresp  = (b == 0) ? resp : 2'b00;
      sbq.push_back('{own, d});
      mid();
      chk("rready", 32'(axi.rready), 32'd1);
      chk("beat_wait", 32'(own ? d_wait : i_wait), 32'(b != RD_BEATS - 1));
      chk("beat_bus_err", 32'(bus_err), 32'((b == RD_BEATS - 1) ? exp_err : 1'b0));
      next_cycle();
      axi.rvalid = 1'b0;
      axi.rlast  = 1'b0;
      axi.rresp  = 2'b00;
    end
  endtask

  task automatic serve_write(input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                             input logic [31:0] exp_wdata, input logic [1:0] resp, input logic exp_err);
    int n = 0;
    mid();
    while (!axi.awvalid && n < 20) begin
      next_cycle();
      mid();
      n++;
    end
    chk("aw_latency", 32'(n), 32'd1);
    axi.awready = 1'b1;
    chk("awaddr", axi.awaddr, exp_addr);
    chk("awlen", 32'(axi.awlen), 32'd0);
    chk("awid", 32'(axi.awid), 32'd1);
    chk("awsize", 32'(axi.awsize), 32'd2);
    chk("awburst", 32'(axi.awburst), 32'd1);
    chk("aw_wait", 32'(d_wait), 32'd1);
    next_cycle();
    axi.awready = 1'b0;
    mid();
    chk("wvalid", 32'(axi.wvalid), 32'd1);
    chk("wlast", 32'(axi.wlast), 32'd1);
    chk("wstrb", 32'(axi.wstrb), 32'(exp_strb));
    chk("wdata", axi.wdata, exp_wdata);
    axi.wready = 1'b1;
    next_cycle();
    axi.wready = 1'b0;
    axi.bvalid = 1'b1;
    axi.bresp  = resp;
    mid();
    chk("bready", 32'(axi.bready), 32'd1);
    chk("b_wait", 32'(d_wait), 32'd0);
    chk("b_bus_err", 32'(bus_err), 32'(exp_err));
    next_cycle();
    axi.bvalid = 1'b0;
    axi.bresp  = 2'b00;
  endtask

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0, 2'd0, 0, 0, 2'b00, 32'h0000_0100, 4'd0, 4'b0000, 32'h0, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_2003, 32'h1234_56AB, 2'd0, 0, 0, 2'b00, 32'h0000_2003, 4'd1, 4'b1000, 32'hABAB_ABAB, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_03FC, 32'h0, 2'd2, 3, 2, 2'b00, 32'h0000_03F0, 4'd1, 4'b0000, 32'h0, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0006, 32'h0000_1234, 2'd1, 0, 0, 2'b10, 32'h0000_0006, 4'd1, 4'b1100, 32'h1234_1234, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2'd3, 0, 0, 2'b00, 32'h0000_0010, 4'd1, 4'b1111, 32'hDEAD_BEEF, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_07FF, 32'h0, 2'd0, 1, 1, 2'b10, 32'h0000_07F0, 4'd0, 4'b0000, 32'h0, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 32'h0000_0001, 32'h0000_005A, 2'd0, 0, 0, 2'b00, 32'h0000_0001, 4'd1, 4'b0010, 32'h5A5A_5A5A, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_0000, 32'hFFFF_CAFE, 2'd1, 0, 0, 2'b00, 32'h0000_0000, 4'd1, 4'b0011, 32'hCAFE_CAFE, 1'b0};

    rst = 1'b1;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_type = 2'd0;
    axi.arready = 1'b0; axi.rid = '0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 1'b0; axi.rvalid = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bid = '0; axi.bresp = 2'b00; axi.bvalid = 1'b0;
    repeat (2) @(posedge clk);
    mid();
    chk("rst_arvalid", 32'(axi.arvalid), 32'd0);
    chk("rst_rready", 32'(axi.rready), 32'd0);
    chk("rst_awvalid", 32'(axi.awvalid), 32'd0);
    chk("rst_wvalid", 32'(axi.wvalid), 32'd0);
    chk("rst_bready", 32'(axi.bready), 32'd0);
    chk("rst_araddr", axi.araddr, 32'd0);
    chk("rst_arlen", 32'(axi.arlen), 32'd0);
    chk("rst_wstrb", 32'(axi.wstrb), 32'd0);
    chk("rst_rvalids", 32'({i_rvalid, d_rvalid, bus_err}), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Simultaneous requests from reset: D wins, I follows after one IDLE cycle.
    i_req = 1'b1; i_addr = 32'h0000_0040;
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h0000_0084;
    serve_read(1'b1, 32'h0000_0080, 4'd1, 0, 0, 2'b00, 1'b0);
    d_req = 1'b0;
    serve_read(1'b0, 32'h0000_0040, 4'd0, 0, 0, 2'b00, 1'b0);
    // Next tie: last grant was I, so D wins again.
    i_req = 1'b1; i_addr = 32'h0000_1010;
    d_req = 1'b1; d_write = 1'b0; d_addr = 32'h0000_2020;
    serve_read(1'b1, 32'h0000_2020, 4'd1, 0, 0, 2'b00, 1'b0);
    d_req = 1'b0;
    serve_read(1'b0, 32'h0000_1010, 4'd0, 0, 0, 2'b00, 1'b0);
    i_req = 1'b0;
    mid();
    next_cycle();

    foreach (vecs[k]) begin
      drive_req(vecs[k]);
      if (vecs[k].wr)
        serve_write(vecs[k].exp_addr, vecs[k].exp_strb, vecs[k].exp_wdata, vecs[k].resp, vecs[k].exp_err);
      else
        serve_read(vecs[k].is_d, vecs[k].exp_addr, vecs[k].exp_id, vecs[k].ar_dly, vecs[k].gap,
                   vecs[k].resp, vecs[k].exp_err);
      i_req = 1'b0;
      d_req = 1'b0;
      mid();
      chk("idle_bus_err", 32'(bus_err), 32'd0);
      next_cycle();
    end

    // Reset in the middle of a burst.
    begin
      logic [31:0] d;
      i_req = 1'b1; i_addr = 32'h0000_0200;
      next_cycle();
      axi.arready = 1'b1;
      mid();
      chk("mid_rst_arvalid", 32'(axi.arvalid), 32'd1);
      next_cycle();
      axi.arready = 1'b0;
      d = $urandom;
      axi.rvalid = 1'b1; axi.rdata = d; axi.rlast = 1'b0;
      sbq.push_back('{1'b0, d});
      mid();
      chk("mid_rst_rready", 32'(axi.rready), 32'd1);
      next_cycle();
      axi.rvalid = 1'b0;
      #1;
      rst = 1'b1;
      i_req = 1'b0;
      #1;
      chk("rst_burst_rready", 32'(axi.rready), 32'd0);
      chk("rst_burst_valids", 32'({axi.arvalid, axi.awvalid, axi.wvalid, axi.bready}), 32'd0);
      chk("rst_burst_rvalid", 32'({i_rvalid, d_rvalid, bus_err}), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      i_req = 1'b1; i_addr = 32'h0000_0300;
      serve_read(1'b0, 32'h0000_0300, 4'd0, 0, 0, 2'b00, 1'b0);
      i_req = 1'b0;
    end

    mid();
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Shares one AXI master port between the L1 instruction cache and the L1 data cache inside the CPU wrapper. Each cache sees a simple req/wait memory interface. The block arbitrates round-robin, latches the winning request, and runs a line-fill burst read or a single-beat write on AXI. It replaces the per-cache point-to-point FSMs, so the wrapper needs only one master port.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (fixed at 32; 4 strobe lanes)
- ID_W, 4, AXI ID width
- RD_BEATS, 4, beats per line-fill read; power of two, 1..16
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- i_req  in  1  I-cache request; read only
- i_addr  in  ADDR_W  I-cache byte address
- i_wait  out  1  I-cache stall
- i_rdata  out  DATA_W  read beat data to I-cache
- i_rvalid  out  1  one-cycle strobe per beat to I-cache
- d_req  in  1  D-cache request
- d_write  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  D-cache byte address
- d_wdata  in  DATA_W  D-cache write data, right-aligned
- d_type  in  2  0 = byte, 1 = halfword, 2 = word
- d_wait  out  1  D-cache stall
- d_rdata  out  DATA_W  read beat data to D-cache
- d_rvalid  out  1  one-cycle strobe per beat to D-cache
- bus_err  out  1  one-cycle pulse at completion if any RRESP/BRESP was nonzero
- AXI AR: ARID[ID_W], ARADDR[ADDR_W], ARLEN[4], ARSIZE[3], ARBURST[2], ARVALID (out); ARREADY (in)
- AXI R: RID, RDATA, RRESP, RLAST, RVALID (in); RREADY (out)
- AXI AW: AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID (out); AWREADY (in)
- AXI W: WDATA, WSTRB[4], WLAST, WVALID (out); WREADY (in)
- AXI B: BID, BRESP, BVALID (in); BREADY (out)

## Operation
- FSM states:
  - IDLE: arbitrate.
  - AR: ARVALID=1, go to R on ARREADY.
  - R: RREADY=1, go to IDLE on RVALID&RLAST.
  - AW: AWVALID=1, go to W on AWREADY.
  - W: WVALID=1, WLAST=1, go to B on WREADY.
  - B: BREADY=1, go to IDLE on BVALID.
- Arbitration in IDLE:
  - Only one requester: grant it.
  - Both requesting: grant the one not granted last.
  - last_grant resets to I, so D wins the first tie after reset.
- At grant, latch owner, address, write flag, write data and type.
- Next state from IDLE: AR for any read, AW for a D write.
- Reads:
  - ARADDR = addr with low log2(RD_BEATS*4) bits cleared.
  - ARLEN = RD_BEATS-1, ARSIZE = 2, ARBURST = INCR.
  - ARID = 0 for I, 1 for D.
- Read beats: each RVALID in R drives RDATA onto the owner's rdata and pulses its rvalid. The other requester's rvalid stays 0.
- Writes:
  - AWLEN = 0, AWSIZE = 2, AWBURST = INCR, AWID = 1, AWADDR = latched addr unaligned.
  - Byte: WSTRB = 1<<addr[1:0], WDATA = byte replicated to all 4 lanes.
  - Halfword: WSTRB = 4'b0011 << {addr[1],1'b0}, WDATA = halfword replicated.
  - Word: WSTRB = 4'b1111.
  - d_type = 3 is treated as word.
- x_wait = x_req & ~(x is owner & completion this cycle).
  - Read completion: R state & RVALID & RLAST.
  - Write completion: B state & BVALID.
  - A requester that is not the owner waits until granted and completed.
- RID/BID are not checked; routing uses the latched owner.
- bus_err accumulates nonzero RRESP/BRESP over the transaction. It pulses with completion and clears in IDLE.
- A requester must hold req and its inputs stable while wait=1.
- If req drops mid-transaction, the bus transaction still completes and rvalid pulses are still issued.

## Timing
- Reset (async): state = IDLE, last_grant = I. All AXI VALIDs and READYs are 0. rvalids, bus_err, latched registers and all AXI payload outputs are 0.
- AXI outputs are registered state decodes; payloads come from latched registers only.
- Grant at edge N, where req is seen in IDLE. ARVALID or AWVALID rises in cycle N+1.
- Minimum read latency: req at cycle 0, AR handshake cycle 1, first beat cycle 2, last beat cycle RD_BEATS+1. wait falls in the last-beat cycle.
- Minimum write: req at 0, AW at 1, W at 2, B at 3; wait falls in cycle 3.
- At least one IDLE cycle separates transactions. A waiting requester is granted at the edge leaving that IDLE cycle.
- VALIDs are held until handshake; payload is stable while VALID=1.
- RVALID without RLAST keeps the FSM in R. RVALID in any state other than R is ignored.

## Test plan
- I read, addr 0x0000_0104, RD_BEATS=4, zero-wait slave -> ARADDR 0x100, ARLEN 3, ARID 0; four i_rvalid pulses in cycles 2..5; i_wait low in cycle 5.
- D byte write, addr 0x0000_2003, wdata 0xAB -> AWADDR 0x2003; WSTRB 4'b1000; WDATA 0xABABABAB; d_wait low when BVALID is seen.
- I and D requesting together from reset -> D served first, then I after one IDLE cycle. Next simultaneous pair -> D first again (last grant was I).
- ARREADY delayed 3 cycles, then 2-cycle RVALID gaps between beats -> ARVALID and ARADDR held steady; exactly 4 rvalid pulses to the owner only.
- BRESP = 2'b10 on a D halfword write at addr 0x6 -> WSTRB 4'b1100; bus_err pulses one cycle with completion.
- rst asserted mid-burst in R state -> all VALIDs/READYs 0 immediately; after release, a new I request issues a fresh AR.
